// File: rtl/rot_shift_pipe_if.sv
// Beat-level handshake bundle for rot_shift_pipe: input beat with per-beat
// cipher controls, and the transformed output beat with its alpha mask.
interface rot_shift_pipe_if #(
  parameter int LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   din;
  logic                 mode;
  logic                 shift_en;
  logic [4:0]           shift_amt;
  logic [2:0]           rot_freq;
  logic                 restart;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   dout;
  logic [LANES-1:0]     alpha_mask;

  modport master (
    output in_valid, din, mode, shift_en, shift_amt, rot_freq, restart, out_ready,
    input  in_ready, out_valid, dout, alpha_mask
  );

  modport slave (
    input  in_valid, din, mode, shift_en, shift_amt, rot_freq, restart, out_ready,
    output in_ready, out_valid, dout, alpha_mask
  );
endinterface

// File: rtl/rot_shift_pipe.sv
// Per-lane Caesar rotation of ASCII beats, 1-cycle latency, output register + skid.
// Key rotation (beat_cnt/offset) is built only when ROT_SHIFT_KEY_ROTATE_EN is defined.
module rot_shift_pipe #(
  parameter int LANES = 4
) (
  input  logic           clk,
  input  logic           rst,
  rot_shift_pipe_if.slave bus
);
  localparam int DATA_W = 8 * LANES;

  function automatic logic [4:0] mod26(input logic [5:0] v);
    return (v >= 6'd26) ? 5'(v - 6'd26) : v[4:0];
  endfunction

  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= 8'd65) && (c <= 8'd90)) || ((c >= 8'd97) && (c <= 8'd122));
  endfunction

  // Caller guarantees c is a letter; the result wraps within the letter's case.
  function automatic logic [7:0] rot_char(input logic [7:0] c, input logic [4:0] eff,
                                          input logic dec);
    logic [7:0]        base;
    logic signed [6:0] idx;
    logic signed [6:0] s;
    logic [6:0]        s_u;
    base = (c >= 8'd97) ? 8'd97 : 8'd65;
    idx  = signed'(7'(c - base));
    s    = dec ? (idx - signed'({2'b00, eff})) : (idx + signed'({2'b00, eff}));
    if (s < 7'sd0)
      s = s + 7'sd26;
    else if (s >= 7'sd26)
      s = s - 7'sd26;
    s_u = 7'(s);
    return base + {1'b0, s_u};
  endfunction

  logic              in_ready_q;
  logic              accept;
  logic              out_xfer;
  logic [4:0]        cur_off;
  logic [4:0]        eff_p0;
  logic [DATA_W-1:0] data_p0;
  logic [LANES-1:0]  mask_p0;
  logic [DATA_W-1:0] data_p1;
  logic [LANES-1:0]  mask_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] skid_data_p1;
  logic [LANES-1:0]  skid_mask_p1;
  logic              skid_vld_p1;

  assign accept   = bus.in_valid & in_ready_q;
  assign out_xfer = vld_p1 & bus.out_ready;

`ifdef ROT_SHIFT_KEY_ROTATE_EN
  logic [2:0] beat_cnt;
  logic [4:0] offset;
  logic [2:0] cnt_inc;

  // A beat accepted alongside restart already sees the cleared offset.
  assign cur_off = bus.restart ? 5'd0 : offset;
  assign cnt_inc = beat_cnt + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= 3'd0;
      offset   <= 5'd0;
    end else if (bus.restart) begin
      beat_cnt <= 3'd0;
      offset   <= 5'd0;
    end else if (accept && (bus.rot_freq != 3'd0)) begin
      if (cnt_inc == bus.rot_freq) begin
        beat_cnt <= 3'd0;
        offset   <= (offset == 5'd25) ? 5'd0 : offset + 5'd1;
      end else begin
        beat_cnt <= cnt_inc;
      end
    end
  end
`else
  logic unused_rot;
  assign cur_off    = 5'd0;
  assign unused_rot = ^{bus.rot_freq, bus.restart};
`endif

  // Stage p0: classify and rotate each lane combinationally from the input beat
  assign eff_p0 = mod26({1'b0, mod26({1'b0, bus.shift_amt})} + {1'b0, cur_off});

  always_comb begin
    data_p0 = bus.din;
    mask_p0 = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.shift_en && is_alpha(bus.din[8*i +: 8])) begin
        data_p0[8*i +: 8] = rot_char(bus.din[8*i +: 8], eff_p0, bus.mode);
        mask_p0[i]        = 1'b1;
      end
    end
  end

  // Stage p1: output register backed by a one-entry skid register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p1      <= '0;
      mask_p1      <= '0;
      vld_p1       <= 1'b0;
      skid_data_p1 <= '0;
      skid_mask_p1 <= '0;
      skid_vld_p1  <= 1'b0;
      in_ready_q   <= 1'b0;
    end else if (skid_vld_p1) begin
      if (out_xfer) begin
        data_p1     <= skid_data_p1;
        mask_p1     <= skid_mask_p1;
        skid_vld_p1 <= 1'b0;
        in_ready_q  <= 1'b1;
      end
    end else if (accept) begin
      if (!vld_p1 || out_xfer) begin
        data_p1    <= data_p0;
        mask_p1    <= mask_p0;
        vld_p1     <= 1'b1;
        in_ready_q <= 1'b1;
      end else begin
        skid_data_p1 <= data_p0;
        skid_mask_p1 <= mask_p0;
        skid_vld_p1  <= 1'b1;
        in_ready_q   <= 1'b0;
      end
    end else begin
      if (out_xfer)
        vld_p1 <= 1'b0;
      in_ready_q <= 1'b1;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = vld_p1;
  assign bus.dout       = data_p1;
  assign bus.alpha_mask = mask_p1;
endmodule
